// File: rtl/gyro_pkg.sv
// Shared encodings for the PmodGYRO axis sampler: byte order within a frame,
// byte-collection FSM states and the assembled three-axis sample.
package gyro_pkg;

  localparam int BYTES_PER_FRAME = 6;
  localparam int SAMPLE_W        = 16;

  typedef enum logic [2:0] {
    IDX_XL = 3'd0,
    IDX_XH = 3'd1,
    IDX_YL = 3'd2,
    IDX_YH = 3'd3,
    IDX_ZL = 3'd4,
    IDX_ZH = 3'd5
  } byte_idx_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] x;
    logic [SAMPLE_W-1:0] y;
    logic [SAMPLE_W-1:0] z;
  } axis_sample_t;

  function automatic byte_idx_e idx_inc(input byte_idx_e idx);
    logic [2:0] v;
    v = idx;
    v = v + 3'd1;
    return byte_idx_e'(v);
  endfunction

endpackage

// File: rtl/axis_accumulator.sv
// Box-average one signed axis over 2^AVG_LOG2 samples; done pulses the cycle
// after the window-closing sample, with avg_o holding the floored mean.
module axis_accumulator
  import gyro_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic                       add_en_i,
  input  logic                       clear_i,
  output logic signed [SAMPLE_W-1:0] avg_o,
  output logic                       done_o
);

  localparam int AW = SAMPLE_W + AVG_LOG2;

  logic signed [AW-1:0]       acc_q, acc_d, sum;
  logic signed [SAMPLE_W-1:0] avg_q, avg_d;
  logic                       done_q, done_d;

  // The closing sample goes into the average but never into the next window.
  always_comb begin
    sum    = acc_q + AW'(sample_i);
    acc_d  = acc_q;
    avg_d  = avg_q;
    done_d = 1'b0;
    if (add_en_i) begin
      if (clear_i) begin
        acc_d  = '0;
        avg_d  = SAMPLE_W'(sum >>> AVG_LOG2);
        done_d = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      avg_q  <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      avg_q  <= avg_d;
      done_q <= done_d;
    end
  end

  assign avg_o  = avg_q;
  assign done_o = done_q;

endmodule

// File: rtl/gyro_axis_sampler.sv
// Assembles X/Y/Z samples from the PmodGYRO byte stream, averages them in
// windows and publishes the result no more often than every HOLD_CYCLES.
module gyro_axis_sampler
  import gyro_pkg::*;
#(
  parameter int AVG_LOG2    = 3,
  parameter int HOLD_CYCLES = 5_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frame_start,
  input  logic                byte_valid,
  input  logic [7:0]          byte_in,
  output logic [SAMPLE_W-1:0] x_axis,
  output logic [SAMPLE_W-1:0] y_axis,
  output logic [SAMPLE_W-1:0] z_axis,
  output logic                axis_upd,
  output logic                frame_err
);

  localparam int FW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [FW-1:0] FRAME_LAST  = FW'((1 << AVG_LOG2) - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

  state_e       state_q, state_d;
  byte_idx_e    idx_q, idx_d;
  byte_idx_e    wr_idx;
  logic         byte_we, sample_done, err_set;
  logic [7:0]   stage_q [BYTES_PER_FRAME-1];
  axis_sample_t sample;

  logic [FW-1:0] frame_cnt_q;
  logic          window_last;

  logic signed [SAMPLE_W-1:0] avg_x, avg_y, avg_z;
  logic                       done_x, done_y, done_z, window_done, publish;
  logic [SAMPLE_W-1:0]        x_axis_q, y_axis_q, z_axis_q;
  logic                       axis_upd_q, frame_err_q;
  logic [HW-1:0]              hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_XL;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // frame_start always wins, even over a byte arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (frame_start) begin
      state_d = ST_COLLECT;
      idx_d   = byte_valid ? IDX_XH : IDX_XL;
    end else if (state_q == ST_COLLECT && byte_valid) begin
      if (idx_q == IDX_ZH) begin
        state_d = ST_IDLE;
        idx_d   = IDX_XL;
      end else begin
        idx_d = idx_inc(idx_q);
      end
    end
  end

  always_comb begin
    byte_we     = 1'b0;
    wr_idx      = idx_q;
    sample_done = 1'b0;
    err_set     = 1'b0;
    if (frame_start) begin
      err_set = (state_q == ST_COLLECT) && (idx_q != IDX_XL);
      byte_we = byte_valid;
      wr_idx  = IDX_XL;
    end else if (state_q == ST_COLLECT && byte_valid) begin
      byte_we     = 1'b1;
      sample_done = (idx_q == IDX_ZH);
    end
  end

  // Z_H is consumed straight off the bus, so only five bytes need staging.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BYTES_PER_FRAME - 1; i++) stage_q[i] <= '0;
    end else if (byte_we && wr_idx != IDX_ZH) begin
      stage_q[wr_idx] <= byte_in;
    end
  end

  always_comb begin
    sample.x = {stage_q[IDX_XH], stage_q[IDX_XL]};
    sample.y = {stage_q[IDX_YH], stage_q[IDX_YL]};
    sample.z = {byte_in, stage_q[IDX_ZL]};
  end

  assign window_last = (frame_cnt_q == FRAME_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (sample_done) begin
      frame_cnt_q <= window_last ? '0 : frame_cnt_q + 1'b1;
    end
  end

  axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc_x (
    .clk     (clk),
    .rst     (rst),
    .sample_i($signed(sample.x)),
    .add_en_i(sample_done),
    .clear_i (window_last),
    .avg_o   (avg_x),
    .done_o  (done_x)
  );

  axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc_y (
    .clk     (clk),
    .rst     (rst),
    .sample_i($signed(sample.y)),
    .add_en_i(sample_done),
    .clear_i (window_last),
    .avg_o   (avg_y),
    .done_o  (done_y)
  );

  axis_accumulator #(.AVG_LOG2(AVG_LOG2)) u_acc_z (
    .clk     (clk),
    .rst     (rst),
    .sample_i($signed(sample.z)),
    .add_en_i(sample_done),
    .clear_i (window_last),
    .avg_o   (avg_z),
    .done_o  (done_z)
  );

  assign window_done = done_x & done_y & done_z;
  assign publish     = window_done && (hold_q == '0);

  // Windows finishing while the hold runs are dropped, not queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_axis_q   <= '0;
      y_axis_q   <= '0;
      z_axis_q   <= '0;
      axis_upd_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      axis_upd_q <= publish;
      if (publish) begin
        x_axis_q <= avg_x;
        y_axis_q <= avg_y;
        z_axis_q <= avg_z;
        hold_q   <= HOLD_RELOAD;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
    end else if (err_set) begin
      frame_err_q <= 1'b1;
    end
  end

  assign x_axis    = x_axis_q;
  assign y_axis    = y_axis_q;
  assign z_axis    = z_axis_q;
  assign axis_upd  = axis_upd_q;
  assign frame_err = frame_err_q;

endmodule
